// File: rtl/flag_stack_register.sv
// Live condition-flag register with masked writes and a LIFO save/restore stack.
// Optional macro FLAG_STICKY_EN adds STICKY_MASK: masked bits accumulate (OR) on write.
module flag_stack_register #(
  parameter int NUM_FLAGS = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
`ifdef FLAG_STICKY_EN
  , parameter logic [NUM_FLAGS-1:0] STICKY_MASK = '0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_enable,
  input  logic [NUM_FLAGS-1:0] write_mask,
  input  logic [NUM_FLAGS-1:0] flags_in,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 err_clr,
  output logic [NUM_FLAGS-1:0] flags_out,
  output logic [CNT_W-1:0]     stack_count,
  output logic                 stack_full,
  output logic                 stack_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

`ifdef FLAG_STICKY_EN
  localparam logic [NUM_FLAGS-1:0] ACCUM_BITS = STICKY_MASK;
`else
  localparam logic [NUM_FLAGS-1:0] ACCUM_BITS = '0;
`endif

  logic [NUM_FLAGS-1:0] mem [DEPTH];

  logic [NUM_FLAGS-1:0] flags_q;
  logic [CNT_W-1:0]     count_q;
  logic                 full_q;
  logic                 empty_q;
  logic                 ovf_q;
  logic                 unf_q;

  logic                 has_entry;
  logic                 do_exch;
  logic                 do_pop;
  logic                 do_push;
  logic                 push_ovf;
  logic                 pop_unf;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     top_idx;
  logic [NUM_FLAGS-1:0] flags_wr;
  logic [NUM_FLAGS-1:0] flags_nxt;
  logic [CNT_W-1:0]     count_nxt;
  logic                 ovf_nxt;
  logic                 unf_nxt;

  // Operation decode. Push+pop on an empty stack degenerates to a plain push.
  always_comb begin
    has_entry = (count_q != '0);
    do_exch   = push & pop & has_entry;
    do_pop    = pop & ~push & has_entry;
    pop_unf   = pop & ~push & ~has_entry;
    do_push   = push & ~do_exch & ~full_q;
    push_ovf  = push & ~do_exch & full_q;
    wr_idx    = IDX_W'(count_q);
    top_idx   = IDX_W'(count_q - CNT_W'(1));
  end

  // Masked write; accumulate bits OR the new value into the live one.
  always_comb begin
    flags_wr = flags_q;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (write_mask[i]) begin
        flags_wr[i] = ACCUM_BITS[i] ? (flags_q[i] | flags_in[i]) : flags_in[i];
      end
    end
  end

  // A restore from the stack takes priority and drops any same-cycle write.
  always_comb begin
    flags_nxt = flags_q;
    count_nxt = count_q;
    if (do_exch || do_pop) begin
      flags_nxt = mem[top_idx];
    end else if (write_enable) begin
      flags_nxt = flags_wr;
    end
    if (do_push) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (do_pop) begin
      count_nxt = count_q - CNT_W'(1);
    end
    ovf_nxt = push_ovf | (ovf_q & ~err_clr);
    unf_nxt = pop_unf  | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_MAX);
      empty_q <= (count_nxt == '0);
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  // Stack storage is not reset; an empty count makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push) begin
        mem[wr_idx] <= flags_q;
      end else if (do_exch) begin
        mem[top_idx] <= flags_q;
      end
    end
  end

  assign flags_out     = flags_q;
  assign stack_count   = count_q;
  assign stack_full    = full_q;
  assign stack_empty   = empty_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_flag_stack_register.sv
// Scoreboard bench for flag_stack_register: queue-based stack model, directed plan then random traffic.
module tb_flag_stack_register;

  localparam int NF    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef FLAG_STICKY_EN
  localparam logic [NF-1:0] STICKY = 4'b0001;
`else
  localparam logic [NF-1:0] STICKY = 4'b0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_enable = 1'b0;
  logic [NF-1:0] write_mask = '0;
  logic [NF-1:0] flags_in = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          err_clr = 1'b0;
  logic [NF-1:0] flags_out;
  logic [CW-1:0] stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          overflow_err;
  logic          underflow_err;

  flag_stack_register #(
    .NUM_FLAGS(NF),
    .DEPTH(DEPTH)
`ifdef FLAG_STICKY_EN
    , .STICKY_MASK(STICKY)
`endif
  ) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .write_mask(write_mask),
    .flags_in(flags_in), .push(push), .pop(pop), .err_clr(err_clr),
    .flags_out(flags_out), .stack_count(stack_count), .stack_full(stack_full),
    .stack_empty(stack_empty), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NF-1:0] flags;
    int            count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic [NF-1:0] m_live = '0;
  logic [NF-1:0] m_stk[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic cmp(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a new registered state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("flags_out",     int'(flags_out),     int'(e.flags));
        cmp("stack_count",   int'(stack_count),   e.count);
        cmp("stack_full",    int'(stack_full),    int'(e.full));
        cmp("stack_empty",   int'(stack_empty),   int'(e.empty));
        cmp("overflow_err",  int'(overflow_err),  int'(e.ovf));
        cmp("underflow_err", int'(underflow_err), int'(e.unf));
      end
    end
  end

  task automatic step(input logic r, input logic we, input logic [NF-1:0] m,
                      input logic [NF-1:0] fi, input logic pu, input logic po,
                      input logic ec);
    exp_t          e;
    logic          n_ovf, n_unf, do_wr;
    logic [NF-1:0] tmp;
    @(negedge clk);
    rst = r; write_enable = we; write_mask = m; flags_in = fi;
    push = pu; pop = po; err_clr = ec;
    if (r) begin
      m_live = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      n_ovf = 1'b0;
      n_unf = 1'b0;
      do_wr = 1'b1;
      if (po && m_stk.size() > 0) begin
        do_wr = 1'b0;
        if (pu) begin
          tmp = m_stk[m_stk.size()-1];
          m_stk[m_stk.size()-1] = m_live;
          m_live = tmp;
        end else begin
          m_live = m_stk.pop_back();
        end
      end else if (pu) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_live);
        else n_ovf = 1'b1;
      end else if (po) begin
        n_unf = 1'b1;
      end
      if (do_wr && we) begin
        for (int i = 0; i < NF; i++)
          if (m[i]) m_live[i] = STICKY[i] ? (m_live[i] | fi[i]) : fi[i];
      end
      m_ovf = n_ovf | (m_ovf & ~ec);
      m_unf = n_unf | (m_unf & ~ec);
    end
    e.flags = m_live;
    e.count = m_stk.size();
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int bias;
    // Reset and first write
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cmp("rst_flags", int'(flags_out), 0);
    cmp("rst_empty", int'(stack_empty), 1);
    step(1'b0, 1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0);
    cmp("wr_flags", int'(flags_out), 'hA);
    cmp("wr_count", int'(stack_count), 0);

    // Push with write saves the pre-write value
    step(1'b0, 1'b1, 4'b1111, 4'b0101, 1'b1, 1'b0, 1'b0);
    cmp("pushwr_flags", int'(flags_out), 'h5);
    cmp("pushwr_count", int'(stack_count), 1);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("pop_restore", int'(flags_out), 'hA);

    // Fill, overflow, drain
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0010, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    cmp("fill_full", int'(stack_full), 1);
    cmp("fill_count", int'(stack_count), 4);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    cmp("ovf_set", int'(overflow_err), 1);
    cmp("ovf_count", int'(stack_count), 4);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("pop1", int'(flags_out), 'h8);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("pop2", int'(flags_out), 'h4);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("pop3", int'(flags_out), 'h2);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("pop4", int'(flags_out), 'h1);
    cmp("drain_empty", int'(stack_empty), 1);

    // Underflow with same-cycle write; then clear
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
    cmp("ovf_clr", int'(overflow_err), 0);
    step(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b1, 1'b0);
    cmp("unf_flags", int'(flags_out), 'h3);
    cmp("unf_set", int'(underflow_err), 1);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    cmp("unf_clr", int'(underflow_err), 0);

    // Error wins over a same-cycle clear
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    cmp("unf_wins", int'(underflow_err), 1);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Exchange
    step(1'b0, 1'b1, 4'b1111, 4'b1100, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
    cmp("exch_flags", int'(flags_out), 'hC);
    cmp("exch_count", int'(stack_count), 1);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("exch_pop", int'(flags_out), 'h3);

    // Push+pop on empty acts as push only
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    cmp("pp_empty_count", int'(stack_count), 1);
    cmp("pp_empty_unf", int'(underflow_err), 0);

`ifdef FLAG_STICKY_EN
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    cmp("sticky_hold", int'(flags_out), 'h1);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    cmp("sticky_pop", int'(flags_out), 'h0);
`endif

    // Mid-sequence reset then randomized traffic
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    cmp("midrst_count", int'(stack_count), 0);
    bias = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) bias = (bias == 60) ? 25 : 60;
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < bias),
           ($urandom_range(0, 99) < (85 - bias)),
           ($urandom_range(0, 7) == 0));
    end
    idle();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
